seg7_scan_driver: RTL

Downstream display stage for the calculator datapath. Takes a 32-bit result word over a one-cycle load strobe and shows it as 8 hex digits on the board's multiplexed 7-segment display. It buffers the word so that display updates land only on frame boundaries and never tear. It time-multiplexes the 8 digits with a programmable dwell time and inserts an anti-ghosting blank gap at the start of every digit slot.

---
 rtl/seg7_scan_driver.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit hex display driver with frame-aligned, tear-free value updates.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero nibble.
module seg7_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    output logic [7:0]  led_en,
    output logic        led_ca,
    output logic        led_cb,
    output logic        led_cc,
    output logic        led_cd,
    output logic        led_ce,
    output logic        led_cf,
    output logic        led_cg,
    output logic        led_dp
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   pending_q, pending_d;
    logic          pending_valid_q, pending_valid_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    en_q, en_d;
    logic [6:0]    seg_q, seg_d;    // active-low, bit 0 = a .. bit 6 = g

    logic          slot_end;
    logic          frame_end;
    logic          in_blank;
    logic [3:0]    nib;
    logic          digit_off;

    // Active-high segment pattern, bit 0 = a .. bit 6 = g.
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0:    hex_seg = 7'h3F;
            4'h1:    hex_seg = 7'h06;
            4'h2:    hex_seg = 7'h5B;
            4'h3:    hex_seg = 7'h4F;
            4'h4:    hex_seg = 7'h66;
            4'h5:    hex_seg = 7'h6D;
            4'h6:    hex_seg = 7'h7D;
            4'h7:    hex_seg = 7'h07;
            4'h8:    hex_seg = 7'h7F;
            4'h9:    hex_seg = 7'h6F;
            4'hA:    hex_seg = 7'h77;
            4'hB:    hex_seg = 7'h7C;
            4'hC:    hex_seg = 7'h39;
            4'hD:    hex_seg = 7'h5E;
            4'hE:    hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] msd;
    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (shadow_q[4*i +: 4] != 4'h0) msd = 3'(i);
        end
    end
    assign digit_off = (idx_q > msd);
`else
    assign digit_off = 1'b0;
`endif

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == 3'd7);
    assign in_blank  = (32'(cnt_q) < 32'(BLANK_CYCLES));
    assign nib       = 4'(shadow_q >> {idx_q, 2'b00});

    always_comb begin
        cnt_d           = slot_end ? '0 : cnt_q + 1'b1;
        idx_d           = slot_end ? idx_q + 3'd1 : idx_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        shadow_d        = shadow_q;

        // Boundary copy sees the pre-load pending; a same-cycle load waits one frame.
        if (frame_end && pending_valid_q) begin
            shadow_d        = pending_q;
            pending_valid_d = 1'b0;
        end
        if (load) begin
            pending_d       = value;
            pending_valid_d = 1'b1;
        end

        en_d  = 8'hFF;
        seg_d = 7'h7F;
        if (!in_blank) begin
            en_d  = ~(8'd1 << idx_q);
            seg_d = digit_off ? 7'h7F : ~hex_seg(nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            idx_q           <= 3'd0;
            pending_q       <= 32'd0;
            pending_valid_q <= 1'b0;
            shadow_q        <= 32'd0;
            en_q            <= 8'hFF;
            seg_q           <= 7'h7F;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            shadow_q        <= shadow_d;
            en_q            <= en_d;
            seg_q           <= seg_d;
        end
    end

    assign led_en = en_q;
    assign led_ca = seg_q[0];
    assign led_cb = seg_q[1];
    assign led_cc = seg_q[2];
    assign led_cd = seg_q[3];
    assign led_ce = seg_q[4];
    assign led_cf = seg_q[5];
    assign led_cg = seg_q[6];
    assign led_dp = 1'b1;

endmodule
